// File: rtl/product_accumulator_pkg.sv
// rtl/product_accumulator_pkg.sv - shared state encoding and default widths for product_accumulator
package product_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int PROD_W_DEF = 32;
    localparam int ACC_W_DEF  = 40;
    localparam int LEN_W_DEF  = 8;

endpackage

// File: rtl/acc_adder.sv
// rtl/acc_adder.sv - unsigned accumulate adder with carry-out; SATURATE_EN clamps to all-ones on carry
module acc_adder #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  result,
    output logic              carry
);

    logic [ACC_W:0] full;

    always_comb begin
        full  = {1'b0, acc} + (ACC_W+1)'(prod);
        carry = full[ACC_W];
`ifdef SATURATE_EN
        // once clamped, any further non-zero add carries again and stays at max
        result = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
        result = full[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums len multiplier products and presents the total on a valid/ready port (SATURATE_EN selects clamping)
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  sum,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              busy,
    output logic              ovf
);

    state_t             state, next_state;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   add_result;
    logic               add_carry;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   len_q;
    logic               ovf_q;
    logic               xfer;
    logic               last;

    acc_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_adder (
        .acc    (acc),
        .prod   (prod),
        .result (add_result),
        .carry  (add_carry)
    );

    assign xfer = prod_valid && (state == ACCUM);
    assign last = (cnt == len_q - LEN_W'(1));

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (len != '0) ? ACCUM : HOLD;
            ACCUM:   if (xfer && last) next_state = HOLD;
            HOLD:    if (sum_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= len;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf_q <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc <= add_result;
                        cnt <= cnt + LEN_W'(1);
                        if (add_carry) ovf_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // acc is frozen outside ACCUM, so it doubles as the held result
    assign sum        = acc;
    assign sum_valid  = (state == HOLD);
    assign prod_ready = (state == ACCUM);
    assign busy       = (state != IDLE);
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed self-checking bench for product_accumulator (default and 33-bit instances)
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic [31:0] prod;
    logic        prod_valid;
    logic        sum_ready;

    logic        prod_ready, sum_valid, busy, ovf;
    logic [39:0] sum;
    logic        prod_ready33, sum_valid33, busy33, ovf33;
    logic [32:0] sum33;

    int checks = 0;
    int errors = 0;

`ifdef SATURATE_EN
    localparam logic [32:0] EXP33 = 33'h1_FFFF_FFFF;
`else
    localparam logic [32:0] EXP33 = 33'h0_FFFF_FFFD;
`endif

    always #5 clk = ~clk;

    product_accumulator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .sum(sum),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .busy(busy), .ovf(ovf)
    );

    product_accumulator #(.ACC_W(33)) dut33 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(prod_ready33), .sum(sum33),
        .sum_valid(sum_valid33), .sum_ready(sum_ready), .busy(busy33), .ovf(ovf33)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; prod = '0; prod_valid = 1'b0; sum_ready = 1'b0;
        step();
        chk("rst_sum", 64'(sum), 0);
        chk("rst_valid", 64'(sum_valid), 0);
        chk("rst_ready", 64'(prod_ready), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_ovf", 64'(ovf), 0);
        rst_n = 1'b1;
        step();

        // 1: len=3, back-to-back 10,20,30
        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0;
        chk("t1_ready", 64'(prod_ready), 1);
        chk("t1_busy", 64'(busy), 1);
        prod_valid = 1'b1; prod = 32'd10; step();
        prod = 32'd20; step();
        chk("t1_valid_early", 64'(sum_valid), 0);
        prod = 32'd30; step();
        prod_valid = 1'b0;
        chk("t1_valid", 64'(sum_valid), 1);
        chk("t1_sum", 64'(sum), 60);
        chk("t1_ovf", 64'(ovf), 0);
        chk("t1_ready_hold", 64'(prod_ready), 0);
        sum_ready = 1'b1; step(); sum_ready = 1'b0;
        chk("t1_idle_valid", 64'(sum_valid), 0);
        chk("t1_idle_busy", 64'(busy), 0);
        chk("t1_sum_retained", 64'(sum), 60);

        // 2: len=4, gapped valid 1,0,1,0,1,1 of 5 each
        start = 1'b1; len = 8'd4; step(); start = 1'b0;
        prod = 32'd5;
        for (int i = 0; i < 6; i++) begin
            prod_valid = (i == 1 || i == 3) ? 1'b0 : 1'b1;
            step();
            chk($sformatf("t2_valid_%0d", i), 64'(sum_valid), (i == 5) ? 1 : 0);
        end
        prod_valid = 1'b0;
        chk("t2_sum", 64'(sum), 20);
        sum_ready = 1'b1; step(); sum_ready = 1'b0;

        // 3: zero-length job
        start = 1'b1; len = 8'd0; step(); start = 1'b0;
        chk("t3_valid", 64'(sum_valid), 1);
        chk("t3_sum", 64'(sum), 0);
        chk("t3_ready", 64'(prod_ready), 0);
        sum_ready = 1'b1; step(); sum_ready = 1'b0;
        chk("t3_ready_after", 64'(prod_ready), 0);
        chk("t3_idle", 64'(busy), 0);

        // 4: overflow on 33-bit instance, 40-bit instance holds exact total
        start = 1'b1; len = 8'd3; step(); start = 1'b0;
        prod_valid = 1'b1; prod = 32'hFFFF_FFFF;
        step(); step(); step();
        prod_valid = 1'b0;
        chk("t4_valid33", 64'(sum_valid33), 1);
        chk("t4_sum33", 64'(sum33), 64'(EXP33));
        chk("t4_ovf33", 64'(ovf33), 1);
        chk("t4_sum40", 64'(sum), 64'h2_FFFF_FFFD);
        chk("t4_ovf40", 64'(ovf), 0);

        // 5: stall in HOLD, start ignored, then start with sum_ready ignored
        for (int i = 0; i < 5; i++) begin
            start = (i == 2); len = 8'd2;
            step();
            chk($sformatf("t5_hold_valid_%0d", i), 64'(sum_valid33), 1);
            chk($sformatf("t5_hold_sum_%0d", i), 64'(sum33), 64'(EXP33));
        end
        start = 1'b1; sum_ready = 1'b1; len = 8'd1;
        step();
        start = 1'b0; sum_ready = 1'b0;
        chk("t5_idle_busy", 64'(busy33), 0);
        chk("t5_ovf_kept", 64'(ovf33), 1);
        start = 1'b1; len = 8'd1; step(); start = 1'b0;
        chk("t5_busy", 64'(busy33), 1);
        chk("t5_ovf_clr", 64'(ovf33), 0);
        prod_valid = 1'b1; prod = 32'd2; step(); prod_valid = 1'b0;
        chk("t5_sum", 64'(sum33), 2);
        sum_ready = 1'b1; step(); sum_ready = 1'b0;

        // 6: reset mid-job, then clean job 7+8
        start = 1'b1; len = 8'd5; step(); start = 1'b0;
        prod_valid = 1'b1; prod = 32'd100; step(); step();
        prod_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_sum", 64'(sum), 0);
        chk("t6_rst_busy", 64'(busy), 0);
        chk("t6_rst_ready", 64'(prod_ready), 0);
        chk("t6_rst_valid", 64'(sum_valid), 0);
        step();
        rst_n = 1'b1;
        step();
        start = 1'b1; len = 8'd2; step(); start = 1'b0;
        prod_valid = 1'b1; prod = 32'd7; step();
        prod = 32'd8; step();
        prod_valid = 1'b0;
        chk("t6_valid", 64'(sum_valid), 1);
        chk("t6_sum", 64'(sum), 15);
        chk("t6_ovf", 64'(ovf), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
